// File: rtl/store_narrow_unit_pkg.sv
// Shared definitions for the narrow store unit: store codes, FSM encoding,
// byte-enable constants and the memory write payload.
package store_narrow_unit_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    // Funct3 store width codes
    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    // Byte-enable patterns
    localparam logic [BE_W-1:0] BE_NONE    = 4'b0000;
    localparam logic [BE_W-1:0] BE_BYTE0   = 4'b0001;
    localparam logic [BE_W-1:0] BE_HALF_LO = 4'b0011;
    localparam logic [BE_W-1:0] BE_HALF_HI = 4'b1100;
    localparam logic [BE_W-1:0] BE_WORD    = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ERR   = 2'd2
    } state_e;

    // One memory write beat as presented on the Mem* outputs
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } mem_wr_t;

    // Clear the byte offset so the memory always sees a word address
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/store_lane_encoder.sv
// Combinational lane steering: replicates store data across byte lanes,
// builds the byte enables and flags illegal width/alignment combinations.
module store_lane_encoder
    import store_narrow_unit_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] dato,
    output logic [DATA_W-1:0] wdata_c,
    output logic [BE_W-1:0]   be_c,
    output logic              illegal_c
);

    // Decode width and offset into lane data and enables
    always_comb begin
        wdata_c   = '0;
        be_c      = BE_NONE;
        illegal_c = 1'b1;
        case (funct3)
            F3_SB: begin
                wdata_c   = {4{dato[7:0]}};
                be_c      = BE_W'(BE_BYTE0 << addr_lo);
                illegal_c = 1'b0;
            end
            F3_SH: begin
                wdata_c   = {2{dato[15:0]}};
                be_c      = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                illegal_c = addr_lo[0];
            end
            F3_SW: begin
                wdata_c   = dato;
                be_c      = BE_WORD;
                illegal_c = (addr_lo != 2'b00);
            end
            default: begin
                wdata_c   = '0;
                be_c      = BE_NONE;
                illegal_c = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_narrow_unit.sv
// Narrow store unit: accepts SB/SH/SW requests from the core, issues one
// lane-replicated word write to data memory and reports Done, Misaligned
// or Timeout as single-cycle pulses.
module store_narrow_unit
    import store_narrow_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              StoreValid,
    output logic              StoreReady,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] Dato,
    input  logic [2:0]        Funct3,
    output logic              MemReq,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    output logic [BE_W-1:0]   MemBE,
    input  logic              MemAck,
    output logic              Done,
    output logic              Misaligned,
    output logic              Timeout
);

    // Counter must be able to hold TIMEOUT-1 for any legal TIMEOUT
    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state;
    logic [CNT_W-1:0]  wait_cnt;
    mem_wr_t           wr_q;
    mem_wr_t           wr_next_c;
    logic [DATA_W-1:0] enc_wdata_c;
    logic [BE_W-1:0]   enc_be_c;
    logic              enc_illegal_c;
    logic              accept_c;
    logic              expire_c;

    // Lane steering for the request currently on the inputs
    store_lane_encoder u_lane_enc (
        .funct3    (Funct3),
        .addr_lo   (Addr[1:0]),
        .dato      (Dato),
        .wdata_c   (enc_wdata_c),
        .be_c      (enc_be_c),
        .illegal_c (enc_illegal_c)
    );

    // Handshake and wait-limit detection
    assign accept_c  = StoreValid && StoreReady;
    assign expire_c  = (wait_cnt == CNT_LAST);
    assign wr_next_c = '{addr: word_align(Addr), wdata: enc_wdata_c, be: enc_be_c};

    // Memory outputs come straight from the registered payload
    assign MemAddr  = wr_q.addr;
    assign MemWData = wr_q.wdata;
    assign MemBE    = wr_q.be;

    // Control FSM, wait counter and registered status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            wr_q       <= '0;
            StoreReady <= 1'b1;
            MemReq     <= 1'b0;
            Done       <= 1'b0;
            Misaligned <= 1'b0;
            Timeout    <= 1'b0;
        end else begin
            Done       <= 1'b0;
            Misaligned <= 1'b0;
            Timeout    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept_c) begin
                        StoreReady <= 1'b0;
                        if (enc_illegal_c) begin
                            state      <= ST_ERR;
                            Misaligned <= 1'b1;
                        end else begin
                            state    <= ST_ISSUE;
                            MemReq   <= 1'b1;
                            wr_q     <= wr_next_c;
                            wait_cnt <= '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    // An acknowledge on the expiry edge still completes the store
                    if (MemAck || expire_c) begin
                        state      <= ST_IDLE;
                        StoreReady <= 1'b1;
                        MemReq     <= 1'b0;
                        wr_q.wdata <= '0;
                        wr_q.be    <= BE_NONE;
                        wait_cnt   <= '0;
                        Done       <= MemAck;
                        Timeout    <= !MemAck;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_ERR: begin
                    state      <= ST_IDLE;
                    StoreReady <= 1'b1;
                end
                default: begin
                    state      <= ST_IDLE;
                    StoreReady <= 1'b1;
                    MemReq     <= 1'b0;
                    wr_q       <= '0;
                    wait_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Self-checking bench for store_narrow_unit: directed and randomized stores
// checked cycle by cycle against a byte-lane arithmetic reference model.
module tb_store_narrow_unit;

    localparam int unsigned TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        StoreValid;
    logic        StoreReady;
    logic [31:0] Addr;
    logic [31:0] Dato;
    logic [2:0]  Funct3;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [3:0]  MemBE;
    logic        MemAck;
    logic        Done;
    logic        Misaligned;
    logic        Timeout;

    int n_cmp = 0;
    int n_bad = 0;

    store_narrow_unit #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .StoreValid (StoreValid),
        .StoreReady (StoreReady),
        .Addr       (Addr),
        .Dato       (Dato),
        .Funct3     (Funct3),
        .MemReq     (MemReq),
        .MemAddr    (MemAddr),
        .MemWData   (MemWData),
        .MemBE      (MemBE),
        .MemAck     (MemAck),
        .Done       (Done),
        .Misaligned (Misaligned),
        .Timeout    (Timeout)
    );

    always #5 clk = ~clk;

    // Reference: access size in bytes, byte i of the word gets data byte (i mod size)
    function automatic void model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                                  output logic ill, output logic [3:0] be, output logic [31:0] wd);
        int sz;
        int off;
        sz  = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
        off = int'(a % 32'd4);
        be  = 4'b0000;
        wd  = 32'h0;
        if (sz == 0) ill = 1'b1;
        else         ill = (off % sz) != 0;
        if (!ill) begin
            for (int i = 0; i < 4; i++) begin
                if (i >= off && i < off + sz) be[i] = 1'b1;
                wd[8*i +: 8] = 8'(d >> (8 * (i % sz)));
            end
        end
    endfunction

    // Drive one request from an idle cycle; returns at the cycle showing its outcome
    task automatic run_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                             input int ack_lat, input bit pre_ack);
        logic        ill;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        bit          acked;
        model(f3, a, d, ill, ebe, ewd);
        n_cmp++;
        if (StoreReady !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_before_req: got %b want 1", StoreReady);
        end
        StoreValid = 1'b1;
        Funct3     = f3;
        Addr       = a;
        Dato       = d;
        if (pre_ack) MemAck = 1'b1;
        @(negedge clk);
        StoreValid = 1'b0;
        Addr       = $urandom;
        Dato       = $urandom;
        Funct3     = 3'($urandom);
        if (ill) begin
            n_cmp++;
            if ({Misaligned, MemReq, StoreReady, Done, Timeout} !== 5'b10000) begin
                n_bad++;
                $display("FAIL err_cycle f3=%b a=%h: got mis/req/rdy/done/tmo=%b want 10000",
                         f3, a, {Misaligned, MemReq, StoreReady, Done, Timeout});
            end
            MemAck = 1'b0;
            @(negedge clk);
            n_cmp++;
            if ({Misaligned, MemReq, StoreReady, MemBE} !== 7'b0010000) begin
                n_bad++;
                $display("FAIL err_exit f3=%b a=%h: got mis/req/rdy/be=%b want 0010000",
                         f3, a, {Misaligned, MemReq, StoreReady, MemBE});
            end
            return;
        end
        acked = 1'b0;
        for (int c = 0; c < int'(TMO) && !acked; c++) begin
            n_cmp++;
            if ({MemReq, StoreReady, Done, Timeout, Misaligned} !== 5'b10000 ||
                MemAddr !== (a & ~32'h3) || MemBE !== ebe || MemWData !== ewd) begin
                n_bad++;
                $display("FAIL issue_cyc%0d f3=%b a=%h: got ctl=%b addr=%h wd=%h be=%b want ctl=10000 addr=%h wd=%h be=%b",
                         c, f3, a, {MemReq, StoreReady, Done, Timeout, Misaligned}, MemAddr, MemWData, MemBE,
                         a & ~32'h3, ewd, ebe);
            end
            if (pre_ack || c == ack_lat) begin
                MemAck = 1'b1;
                acked  = 1'b1;
            end
            @(negedge clk);
            MemAck = 1'b0;
        end
        n_cmp++;
        if (acked) begin
            if ({Done, Timeout, Misaligned, MemReq, StoreReady} !== 5'b10001 || MemBE !== 4'b0 || MemWData !== 32'h0) begin
                n_bad++;
                $display("FAIL done_cycle a=%h lat=%0d: got done/tmo/mis/req/rdy=%b be=%b wd=%h want 10001 be=0000 wd=0",
                         a, ack_lat, {Done, Timeout, Misaligned, MemReq, StoreReady}, MemBE, MemWData);
            end
        end else begin
            if ({Done, Timeout, Misaligned, MemReq, StoreReady} !== 5'b01001 || MemBE !== 4'b0 || MemWData !== 32'h0) begin
                n_bad++;
                $display("FAIL timeout_cycle a=%h: got done/tmo/mis/req/rdy=%b be=%b wd=%h want 01001 be=0000 wd=0",
                         a, {Done, Timeout, Misaligned, MemReq, StoreReady}, MemBE, MemWData);
            end
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        StoreValid = 1'b0;
        MemAck     = 1'b0;
        Addr       = 32'h0;
        Dato       = 32'h0;
        Funct3     = 3'b000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({StoreReady, MemReq, Done, Misaligned, Timeout} !== 5'b10000) begin
            n_bad++;
            $display("FAIL reset_ctl: got rdy/req/done/mis/tmo=%b want 10000",
                     {StoreReady, MemReq, Done, Misaligned, Timeout});
        end
        n_cmp++;
        if (MemAddr !== 32'h0 || MemWData !== 32'h0 || MemBE !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_mem: got addr=%h wd=%h be=%b want 0/0/0", MemAddr, MemWData, MemBE);
        end
    endtask

    task automatic test_directed();
        run_store(3'b000, 32'h0000_1003, 32'h1234_56AB, 1, 1'b0);
        run_store(3'b001, 32'h0000_0002, 32'hFFFF_8001, 0, 1'b0);
        run_store(3'b001, 32'h0000_0001, 32'hFFFF_8001, 0, 1'b0);
        run_store(3'b010, 32'h0000_0010, 32'hFFFF_F801, 0, 1'b1);
        run_store(3'b011, 32'h0000_0010, 32'hFFFF_F801, 0, 1'b0);
        run_store(3'b010, 32'h0000_0006, 32'hCAFE_F00D, 0, 1'b0);
        run_store(3'b001, 32'h0000_0003, 32'h0000_BEEF, 0, 1'b0);
    endtask

    task automatic test_timeout();
        run_store(3'b010, 32'h0000_0020, 32'h0BAD_CAFE, 1000, 1'b0);
        run_store(3'b000, 32'h0000_0021, 32'h0000_0077, int'(TMO) - 1, 1'b0);
        run_store(3'b001, 32'h0000_0022, 32'h0000_1234, int'(TMO) - 2, 1'b0);
    endtask

    task automatic test_reset_mid_issue();
        bit seen;
        StoreValid = 1'b1;
        Funct3     = 3'b010;
        Addr       = 32'h0000_0040;
        Dato       = 32'h1111_2222;
        @(negedge clk);
        StoreValid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (MemReq !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_issue_req: got %b want 1", MemReq);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({MemReq, StoreReady, Done, Timeout} !== 4'b0100 || MemBE !== 4'b0 || MemWData !== 32'h0 || MemAddr !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_abandon: got req/rdy/done/tmo=%b be=%b wd=%h addr=%h want 0100 0 0 0",
                     {MemReq, StoreReady, Done, Timeout}, MemBE, MemWData, MemAddr);
        end
        seen = 1'b0;
        for (int c = 0; c < int'(TMO) + 8; c++) begin
            @(negedge clk);
            if (Done || Timeout || MemReq) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_no_pulse: got activity=%b want 0", seen);
        end
        run_store(3'b000, 32'h0000_0101, 32'h0000_00C3, 2, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_store(3'b000, 32'h0000_0200, 32'hA1B2_C3D4, 0, 1'b0);
        run_store(3'b001, 32'h0000_0202, 32'h5566_7788, 0, 1'b1);
        run_store(3'b010, 32'h0000_0205, 32'h0, 0, 1'b0);
        run_store(3'b010, 32'h0000_0204, 32'h9ABC_DEF0, 3, 1'b0);
        run_store(3'b111, 32'h0000_0208, 32'h1, 0, 1'b0);
        run_store(3'b000, 32'h0000_0209, 32'h0000_0055, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a;
        int          lat;
        int          r;
        for (int it = 0; it < 80; it++) begin
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                StoreValid = 1'b0;
                MemAck     = 1'($urandom);
                @(negedge clk);
                MemAck = 1'b0;
                n_cmp++;
                if ({MemReq, Done, Timeout, Misaligned, StoreReady} !== 5'b00001) begin
                    n_bad++;
                    $display("FAIL idle_gap it=%0d: got req/done/tmo/mis/rdy=%b want 00001",
                             it, {MemReq, Done, Timeout, Misaligned, StoreReady});
                end
            end
            r  = int'($urandom_range(0, 9));
            f3 = (r < 8) ? 3'(r % 3) : 3'($urandom_range(3, 7));
            a  = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            r = int'($urandom_range(0, 9));
            lat = (r < 7) ? int'($urandom_range(0, 4)) : (r < 9) ? int'(TMO) - 1 : 1000;
            run_store(f3, a, $urandom, lat, $urandom_range(0, 5) == 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_reset_mid_issue();
        test_back_to_back();
        test_random();
        @(negedge clk);
        n_cmp++;
        if ({Done, Timeout, Misaligned, MemReq, StoreReady} !== 5'b00001) begin
            n_bad++;
            $display("FAIL final_idle: got done/tmo/mis/req/rdy=%b want 00001",
                     {Done, Timeout, Misaligned, MemReq, StoreReady});
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/store_narrow_unit.md
STORE_NARROW_UNIT -- requirements
Module: store_narrow_unit

Interface
REQ-001 Parameter: TIMEOUT, default 16, max cycles waiting for MemAck before abort.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 StoreValid  input  1  core presents a store request.
REQ-005 StoreReady  output  1  unit can accept a request (high only in IDLE).
REQ-006 Addr  input  32  byte address of store.
REQ-007 Dato  input  32  register data to store.
REQ-008 Funct3  input  3  store width: 000 SB, 001 SH, 010 SW; other values illegal.
REQ-009 MemReq  output  1  write request to data memory.
REQ-010 MemAddr  output  32  word-aligned address, {Addr[31:2],2'b00}.
REQ-011 MemWData  output  32  lane-replicated write data.
REQ-012 MemBE  output  4  byte enables.
REQ-013 MemAck  input  1  memory accepted the write.
REQ-014 Done  output  1  one-cycle pulse: store completed.
REQ-015 Misaligned  output  1  one-cycle pulse: misaligned or illegal request rejected.
REQ-016 Timeout  output  1  one-cycle pulse: MemAck not received within TIMEOUT cycles.

Function
REQ-017 Handshake: request accepted on an edge where StoreValid and StoreReady are both high; Addr/Dato/Funct3 registered then.
REQ-018 States: IDLE, ISSUE, ERR; encoding from shared package.
REQ-019 IDLE: StoreReady=1, MemReq=0; legal accept -> ISSUE; illegal/misaligned accept -> ERR.
REQ-020 SB: MemWData={4{Dato[7:0]}}, MemBE=4'b0001<<Addr[1:0]; always legal.
REQ-021 SH: legal only if Addr[0]=0; MemWData={2{Dato[15:0]}}, MemBE=Addr[1]?4'b1100:4'b0011.
REQ-022 SW: legal only if Addr[1:0]=00; MemWData=Dato, MemBE=4'b1111.
REQ-023 Funct3 not in {000,001,010}: treated as illegal -> ERR.
REQ-024 ISSUE: MemReq=1 with MemAddr/MemWData/MemBE stable until the cycle MemAck is sampled high.
REQ-025 Latency: accept at edge N -> MemReq high from cycle N+1; MemAck sampled at edge M -> MemReq=0, Done=1, StoreReady=1 in cycle M+1 (IDLE).
REQ-026 MemAck in same cycle MemReq first rises is valid (minimum accept-to-Done 2 cycles).
REQ-027 MemAck while MemReq=0 ignored.
REQ-028 ISSUE wait counter increments each cycle without MemAck; after TIMEOUT cycles -> IDLE with Timeout=1 one cycle, MemReq=0; MemAck on the same edge as expiry wins (Done, no Timeout).
REQ-029 ERR: one cycle, Misaligned=1, StoreReady=0, MemReq=0; then IDLE.
REQ-030 Done, Misaligned, Timeout mutually exclusive; each registered, never high two consecutive cycles from one request.
REQ-031 MemBE=0000 and MemWData=0 whenever MemReq=0.

Reset
REQ-032 rst high at an edge: state=IDLE, MemReq=0, MemBE=0, MemWData=0, MemAddr=0, Done=Misaligned=Timeout=0, wait counter=0, StoreReady=1 next cycle.
REQ-033 Reset mid-ISSUE abandons the request; no Done/Timeout pulse produced.

Structure
REQ-034 Shared package holds Funct3 store codes, state encoding, and BE constants (BE_BYTE0, BE_HALF_LO, BE_HALF_HI, BE_WORD).
REQ-035 One combinational sub-module store_lane_encoder (Funct3, Addr[1:0], Dato -> WData, BE, Illegal); FSM and counter in top.

Verification
REQ-036 SB Addr=0x00001003 Dato=0x123456AB, MemAck one cycle after MemReq -> MemAddr=0x00001000, MemWData=0xABABABAB, MemBE=1000, Done pulse.
REQ-037 SH Addr=0x00000002 Dato=0xFFFF8001 -> MemWData=0x80018001, MemBE=1100; SH Addr=0x00000001 -> Misaligned pulse, MemReq never high.
REQ-038 SW Addr=0x00000010 Dato=0xFFFFF801, MemAck held high -> Done two cycles after accept, MemBE=1111; Funct3=011 -> Misaligned pulse.
REQ-039 SW with MemAck never asserted, TIMEOUT=16 -> MemReq high exactly 16 cycles, then Timeout pulse, StoreReady=1.
REQ-040 rst asserted during ISSUE -> MemReq=0 next cycle, no Done/Timeout; new SB accepted afterwards completes normally.
